// File: rtl/bsv32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : bsv32i_pkg                                                      |
// | Purpose  : Shared RV32I load/store func3 encodings, the data-memory        |
// |            controller state type and the access-legality helper.          |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package bsv32i_pkg;

  // Load encodings
  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] c_SB  = 3'b000;
  localparam logic [2:0] c_SH  = 3'b001;
  localparam logic [2:0] c_SW  = 3'b010;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_t;

  // Returns 1 when the access must be rejected: reserved encodings,
  // misaligned half/word accesses, and unsigned-load encodings used on a store.
  function automatic logic dmem_access_bad(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic bad;
    case (f3)
      c_LB:          bad = 1'b0;
      c_LH:          bad = lane[0];
      c_LW:          bad = |lane;
      c_LBU:         bad = is_store;
      c_LHU:         bad = is_store | lane[0];
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: dmem_ctrl_if                                                    |
// | Purpose  : EX-stage to data-memory request/response bundle.                |
// | Signals  : mem_read_en, mem_write_en, func3, mem_address, mem_data_in      |
// |            (requester -> controller); mem_data_out, load_valid,            |
// |            access_fault, busy (controller -> requester).                   |
// | Modports : master = requester, slave = controller.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface dmem_ctrl_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
);
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [2:0]           func3;
  logic [AddrWidth-1:0] mem_address;
  logic [DataWidth-1:0] mem_data_in;
  logic [DataWidth-1:0] mem_data_out;
  logic                 load_valid;
  logic                 access_fault;
  logic                 busy;

  modport master (
    output mem_read_en, mem_write_en, func3, mem_address, mem_data_in,
    input  mem_data_out, load_valid, access_fault, busy
  );

  modport slave (
    input  mem_read_en, mem_write_en, func3, mem_address, mem_data_in,
    output mem_data_out, load_valid, access_fault, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_bank                                                       |
// | Purpose  : Word-organised RAM, synchronous read, per-byte write enables.   |
// | Ports    : clock   - rising-edge clock                                     |
// |            i_we    - byte write enables, bit n covers bits [8n+7:8n]       |
// |            i_waddr - write word index                                      |
// |            i_wdata - write data (lane-aligned)                             |
// |            i_raddr - read word index                                       |
// |            o_rdata - registered read data (old data on same-cycle write)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_bank #(
  parameter int DataWidth = 32,
  parameter int IdxWidth  = 8
) (
  input  wire logic                 clock,
  input  wire logic [3:0]           i_we,
  input  wire logic [IdxWidth-1:0]  i_waddr,
  input  wire logic [DataWidth-1:0] i_wdata,
  input  wire logic [IdxWidth-1:0]  i_raddr,
  output logic      [DataWidth-1:0] o_rdata
);
  localparam int c_DEPTH = 1 << IdxWidth;

  // Contents are deliberately not reset; the controller clears them.
  logic [DataWidth-1:0] r_mem [0:c_DEPTH-1];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    o_rdata <= r_mem[i_raddr];
  end
endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_ctrl                                                       |
// | Purpose  : RV32I data-memory controller. Clears the RAM after reset        |
// |            (INIT), then serves byte/half/word loads and stores (RUN) with  |
// |            lane steering, sign/zero extension and alignment checks.        |
// | Ports    : clock - rising-edge clock                                       |
// |            reset - synchronous active-high reset                           |
// |            bus   - dmem_ctrl_if.slave (requests in, load data/status out)  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_ctrl
  import bsv32i_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
) (
  input  wire logic clock,
  input  wire logic reset,
  dmem_ctrl_if.slave bus
);
  localparam int                  c_IDX_WIDTH = AddrWidth - 2;
  localparam logic [c_IDX_WIDTH-1:0] c_LAST_IDX = '1;

  dmem_state_t              r_state;
  dmem_state_t              w_state_nxt;
  logic [c_IDX_WIDTH-1:0]   r_clr_idx;

  logic                     r_load_pend;
  logic                     r_fault;
  logic [2:0]               r_f3;
  logic [1:0]               r_lane;
  logic [DataWidth-1:0]     r_data_hold;

  logic                     w_busy;
  logic                     w_run;
  logic [c_IDX_WIDTH-1:0]   w_idx;
  logic [1:0]               w_lane;
  logic                     w_is_store;
  logic                     w_fault;
  logic                     w_store_ok;
  logic                     w_load_ok;
  logic [3:0]               w_st_be;
  logic [DataWidth-1:0]     w_st_data;

  logic [3:0]               w_bank_we;
  logic [c_IDX_WIDTH-1:0]   w_bank_waddr;
  logic [DataWidth-1:0]     w_bank_wdata;
  logic [DataWidth-1:0]     w_bank_rdata;

  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [DataWidth-1:0]     w_load_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && r_clr_idx == c_LAST_IDX) begin
      w_state_nxt = RUN;
    end
  end

  always_comb begin
    w_busy = (r_state == INIT);
    w_run  = (r_state == RUN);
  end

  // Clear pointer walks every word once; it wraps to 0 as RUN is entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_idx <= '0;
    end else if (r_state == INIT) begin
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------- request decode
  assign w_idx      = bus.mem_address[AddrWidth-1:2];
  assign w_lane     = bus.mem_address[1:0];
  // A simultaneous read+write is treated purely as a store.
  assign w_is_store = bus.mem_write_en;

  always_comb begin
    w_fault    = 1'b0;
    w_store_ok = 1'b0;
    w_load_ok  = 1'b0;
    if (w_run && (bus.mem_read_en || bus.mem_write_en)) begin
      w_fault    = dmem_access_bad(w_is_store, bus.func3, w_lane);
      w_store_ok = w_is_store && !w_fault;
      w_load_ok  = !w_is_store && !w_fault;
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_st_be   = 4'b1111;
    w_st_data = bus.mem_data_in;
    case (bus.func3)
      c_SB: begin
        w_st_be   = 4'b0001 << w_lane;
        w_st_data = {4{bus.mem_data_in[7:0]}};
      end
      c_SH: begin
        w_st_be   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{bus.mem_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  // The single write port is shared: INIT owns it for clearing, RUN for stores.
  always_comb begin
    if (w_run) begin
      w_bank_we    = w_store_ok ? w_st_be : 4'b0000;
      w_bank_waddr = w_idx;
      w_bank_wdata = w_st_data;
    end else begin
      w_bank_we    = 4'b1111;
      w_bank_waddr = r_clr_idx;
      w_bank_wdata = '0;
    end
  end

  dmem_bank #(
    .DataWidth (DataWidth),
    .IdxWidth  (c_IDX_WIDTH)
  ) u_bank (
    .clock   (clock),
    .i_we    (w_bank_we),
    .i_waddr (w_bank_waddr),
    .i_wdata (w_bank_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_bank_rdata)
  );

  // ---------------------------------------------------------------- response stage
  always_ff @(posedge clock) begin
    if (reset) begin
      r_load_pend <= 1'b0;
      r_fault     <= 1'b0;
      r_f3        <= 3'b000;
      r_lane      <= 2'b00;
    end else begin
      r_load_pend <= w_load_ok;
      r_fault     <= w_fault;
      r_f3        <= bus.func3;
      r_lane      <= w_lane;
    end
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = w_bank_rdata[7:0];
      2'd1:    w_byte = w_bank_rdata[15:8];
      2'd2:    w_byte = w_bank_rdata[23:16];
      default: w_byte = w_bank_rdata[31:24];
    endcase
    w_half = r_lane[1] ? w_bank_rdata[31:16] : w_bank_rdata[15:0];
    case (r_f3)
      c_LB:    w_load_data = {{24{w_byte[7]}}, w_byte};
      c_LH:    w_load_data = {{16{w_half[15]}}, w_half};
      c_LBU:   w_load_data = {24'h000000, w_byte};
      c_LHU:   w_load_data = {16'h0000, w_half};
      default: w_load_data = w_bank_rdata;
    endcase
  end

  // RAM read data is only valid in the completion cycle, so it is captured
  // there to hold mem_data_out steady afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_hold <= '0;
    end else if (r_load_pend) begin
      r_data_hold <= w_load_data;
    end
  end

  assign bus.mem_data_out = r_load_pend ? w_load_data : r_data_hold;
  assign bus.load_valid   = r_load_pend;
  assign bus.access_fault = r_fault;
  assign bus.busy         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_ctrl                                                    |
// | Purpose  : Self-checking bench for dmem_ctrl: word-array reference model   |
// |            compared every cycle, plus directed literal expectations.       |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dmem_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_ctrl_if #(.DataWidth(32), .AddrWidth(10)) bus ();

  dmem_ctrl #(.DataWidth(32), .AddrWidth(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [31:0] m_mem [0:255];
  int          m_clr     = 0;
  bit          m_started = 1'b0;
  logic        m_lv      = 1'b0;
  logic        m_af      = 1'b0;
  logic [31:0] m_out     = 32'h0;

  function automatic bit legal(input bit is_store, input int f, input int a);
    int l = a % 4;
    if (is_store)
      return (f == 0) || (f == 1 && l % 2 == 0) || (f == 2 && l == 0);
    return (f == 0) || (f == 4) || ((f == 1 || f == 5) && l % 2 == 0) || (f == 2 && l == 0);
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_started = 1'b1;
        m_clr = 0; m_lv = 1'b0; m_af = 1'b0; m_out = 32'h0;
      end else if (m_started) begin
        m_lv = 1'b0; m_af = 1'b0;
        if (m_clr < 256) begin
          m_mem[m_clr] = 32'h0;
          m_clr++;
        end else if (bus.mem_read_en || bus.mem_write_en) begin
          int a, w, l, f;
          logic [31:0] word;
          logic [7:0]  b;
          logic [15:0] h;
          a = int'(bus.mem_address); w = a / 4; l = a % 4; f = int'(bus.func3);
          word = m_mem[w];
          if (bus.mem_write_en) begin
            if (!legal(1, f, a)) m_af = 1'b1;
            else begin
              if (f == 0) word[8*l +: 8] = bus.mem_data_in[7:0];
              else if (f == 1) word[8*l +: 16] = bus.mem_data_in[15:0];
              else word = bus.mem_data_in;
              m_mem[w] = word;
            end
          end else begin
            if (!legal(0, f, a)) m_af = 1'b1;
            else begin
              b = word[8*l +: 8];
              h = word[8*(l - l % 2) +: 16];
              m_lv = 1'b1;
              case (f)
                0: m_out = {{24{b[7]}}, b};
                1: m_out = {{16{h[15]}}, h};
                4: m_out = {24'h0, b};
                5: m_out = {16'h0, h};
                default: m_out = word;
              endcase
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (m_started) begin
        chk("busy",         {31'h0, bus.busy},         {31'h0, m_clr < 256});
        chk("load_valid",   {31'h0, bus.load_valid},   {31'h0, m_lv});
        chk("access_fault", {31'h0, bus.access_fault}, {31'h0, m_af});
        chk("mem_data_out", bus.mem_data_out, m_out);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  task automatic set_req(input logic rd, input logic wr, input logic [2:0] f,
                         input logic [9:0] a, input logic [31:0] d);
    bus.mem_read_en  = rd;
    bus.mem_write_en = wr;
    bus.func3        = f;
    bus.mem_address  = a;
    bus.mem_data_in  = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
  endtask

  // Issue one request for a single cycle; returns in the completion cycle.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f,
                     input logic [9:0] a, input logic [31:0] d);
    set_req(rd, wr, f, a, d);
    step();
    idle();
  endtask

  task automatic chk_load(input string name, input logic [31:0] exp);
    chk({name, "_valid"}, {31'h0, bus.load_valid}, 32'h1);
    chk({name, "_data"},  bus.mem_data_out, exp);
  endtask

  task automatic chk_fault(input string name);
    chk({name, "_fault"}, {31'h0, bus.access_fault}, 32'h1);
    chk({name, "_noload"}, {31'h0, bus.load_valid}, 32'h0);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    chk(name, n, 256);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    chk("rst_busy", {31'h0, bus.busy}, 32'h1);
    chk("rst_lv",   {31'h0, bus.load_valid}, 32'h0);
    chk("rst_af",   {31'h0, bus.access_fault}, 32'h0);
    chk("rst_out",  bus.mem_data_out, 32'h0);
    step();
    reset = 1'b0;
    count_busy("init_len");

    txn(1, 0, 3'b010, 10'h3FC, 32'h0);
    chk_load("lw_3fc", 32'h00000000);

    txn(0, 1, 3'b010, 10'h010, 32'h8899AABB);
    txn(0, 1, 3'b000, 10'h012, 32'h000000EE);
    txn(1, 0, 3'b010, 10'h010, 32'h0);
    chk_load("lw_010", 32'h88EEAABB);

    txn(0, 1, 3'b010, 10'h020, 32'h80FF7F01);
    txn(1, 0, 3'b000, 10'h022, 32'h0);
    chk_load("lb_022", 32'hFFFFFFFF);
    txn(1, 0, 3'b100, 10'h022, 32'h0);
    chk_load("lbu_022", 32'h000000FF);
    txn(1, 0, 3'b001, 10'h022, 32'h0);
    chk_load("lh_022", 32'hFFFF80FF);
    txn(1, 0, 3'b101, 10'h020, 32'h0);
    chk_load("lhu_020", 32'h00007F01);

    txn(1, 0, 3'b010, 10'h021, 32'h0);
    chk_fault("lw_021");
    txn(0, 1, 3'b001, 10'h023, 32'h0000DEAD);
    chk_fault("sh_023");
    txn(1, 0, 3'b011, 10'h020, 32'h0);
    chk_fault("f3_011");
    txn(1, 0, 3'b010, 10'h020, 32'h0);
    chk_load("lw_020_after_faults", 32'h80FF7F01);

    txn(1, 1, 3'b010, 10'h030, 32'h12345678);
    chk("rdwr_lv", {31'h0, bus.load_valid}, 32'h0);
    chk("rdwr_af", {31'h0, bus.access_fault}, 32'h0);
    txn(1, 0, 3'b010, 10'h030, 32'h0);
    chk_load("lw_030", 32'h12345678);

    txn(0, 1, 3'b001, 10'h012, 32'h5555BEEF);
    txn(1, 0, 3'b010, 10'h010, 32'h0);
    chk_load("sh_upper", 32'hBEEFAABB);
    txn(0, 1, 3'b100, 10'h010, 32'hFFFFFFFF);
    chk_fault("store_lbu");

    // Back-to-back loads, one per cycle.
    set_req(1, 0, 3'b010, 10'h010, 32'h0); step();
    chk_load("b2b_0", 32'hBEEFAABB);
    set_req(1, 0, 3'b010, 10'h020, 32'h0); step();
    chk_load("b2b_1", 32'h80FF7F01);
    set_req(1, 0, 3'b100, 10'h011, 32'h0); step();
    chk_load("b2b_2", 32'h000000AA);
    set_req(1, 0, 3'b001, 10'h012, 32'h0); step();
    chk_load("b2b_3", 32'hFFFFBEEF);
    idle(); step();
    chk("hold_lv",  {31'h0, bus.load_valid}, 32'h0);
    chk("hold_out", bus.mem_data_out, 32'hFFFFBEEF);

    // Reset together with a load request: the load must vanish.
    set_req(1, 0, 3'b010, 10'h010, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    chk("rst_load_lv",  {31'h0, bus.load_valid}, 32'h0);
    chk("rst_load_out", bus.mem_data_out, 32'h0);

    txn(1, 0, 3'b010, 10'h010, 32'h0);
    chk("init_req_lv", {31'h0, bus.load_valid}, 32'h0);
    chk("init_req_af", {31'h0, bus.access_fault}, 32'h0);
    repeat (99) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy("reinit_len");

    txn(1, 0, 3'b010, 10'h010, 32'h0);
    chk_load("lw_010_cleared", 32'h00000000);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DataWidth, default 32, data word width; only 32 is supported.
REQ-002 Parameter AddrWidth, default 10, byte-address width; the RAM holds 2^(AddrWidth-2) words.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_read_en  input  1  load request from the EX stage.
REQ-006 mem_write_en  input  1  store request from the EX stage.
REQ-007 func3  input  3  access size/sign, RV32I load/store encoding.
REQ-008 mem_address  input  AddrWidth  byte address of the access.
REQ-009 mem_data_in  input  DataWidth  store data, right-aligned.
REQ-010 mem_data_out  output  DataWidth  aligned, extended load result.
REQ-011 load_valid  output  1  single-cycle pulse marking mem_data_out updated.
REQ-012 access_fault  output  1  single-cycle pulse marking a rejected access.
REQ-013 busy  output  1  high while the controller is clearing memory; requests are ignored.

Function
REQ-014 The FSM SHALL have two states: INIT and RUN.
- Reset enters INIT with clear counter = 0.
REQ-015 In INIT, the block SHALL write zero to word[counter] every cycle and increment the counter.
- On the cycle after the write to the last word (2^(AddrWidth-2)-1), the FSM SHALL enter RUN.
- INIT lasts exactly 2^(AddrWidth-2) cycles (256 at default).
REQ-016 busy SHALL be 1 in INIT and 0 in RUN.
- Requests in INIT: no RAM write, no load_valid, no access_fault.
REQ-017 Word index SHALL be mem_address[AddrWidth-1:2]; byte lane SHALL be mem_address[1:0].
REQ-018 Store SB (func3=000) SHALL write mem_data_in[7:0] to the lane selected by address[1:0] only.
- Store SH (001) SHALL write mem_data_in[15:0] to lanes {1,0} when address[1]=0, else lanes {3,2}.
- Store SW (010) SHALL write all four lanes.
REQ-019 Stores SHALL complete in the request cycle.
- A load of the same word in the next cycle SHALL return the new data.
REQ-020 Loads SHALL have latency 1: request in cycle N -> load_valid=1 and mem_data_out valid in cycle N+1.
REQ-021 Load extraction SHALL use func3 and address[1:0] registered in cycle N.
- LB (000) / LH (001) sign-extend.
- LBU (100) / LHU (101) zero-extend.
- LW (010) passes the word unchanged.
REQ-022 mem_data_out SHALL hold its last value when no load completes.
REQ-023 A fault SHALL occur for any of:
- func3 in {011, 110, 111};
- LH, LHU or SH with address[0]=1;
- LW or SW with address[1:0]!=00;
- a store with func3 of LBU or LHU.
REQ-024 A faulting access SHALL suppress the RAM write and load_valid, and SHALL pulse access_fault in cycle N+1.
REQ-025 When mem_read_en and mem_write_en are both 1, the block SHALL perform the store only: no load_valid, no fault from the read.
REQ-026 Back-to-back loads on consecutive cycles SHALL each produce one load_valid pulse, in order, with no bubble.

Reset
REQ-027 Reset SHALL force:
- mem_data_out = 0;
- load_valid = 0;
- access_fault = 0;
- busy = 1;
- state = INIT;
- counter = 0;
- registered func3 and lane = 0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart clearing from word 0.
- Any load in flight SHALL be discarded: no load_valid after reset.
REQ-029 RAM contents SHALL not be reset directly; they are zeroed only by INIT.

Structure
REQ-030 A shared package bsv32i_pkg SHALL hold:
- the func3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW);
- the dmem_state_t enum {INIT, RUN}.
REQ-031 The storage SHALL be one sub-module, dmem_bank.
- Synchronous read, 4-bit byte-write-enable, depth 2^(AddrWidth-2) x 32.
- Lane steering, extension, fault checks and the FSM stay in dmem_ctrl.

Verification
REQ-032 Reset, then hold idle -> busy=1 for exactly 256 cycles, then 0; LW of address 0x3FC -> 0x00000000.
REQ-033 SW 0x8899AABB @0x010, then SB 0xEE @0x012 -> LW @0x010 returns 0x88EEAABB one cycle after request.
REQ-034 Word 0x80FF7F01 @0x020:
- LB @0x022 -> 0xFFFFFFFF;
- LBU @0x022 -> 0x000000FF;
- LH @0x022 -> 0xFFFF80FF;
- LHU @0x020 -> 0x00007F01.
REQ-035 LW @0x021, SH @0x023, func3=011 -> access_fault pulse each; memory unchanged; no load_valid.
REQ-036 Simultaneous read+write SW 0x12345678 @0x030 -> no load_valid; next-cycle LW returns 0x12345678.
REQ-037 Reset asserted during a load and at INIT count 100 -> no load_valid; busy high for 256 further cycles.
